tinv_bus_enable_seq: RTL and testbench



---
 rtl/tinv_bus_enable_seq_pkg.sv | 14 +
 rtl/tinv_bus_enable_seq_if.sv | 11 +
 rtl/tinv_bus_enable_seq_rr_pick.sv | 20 ++
 rtl/tinv_bus_enable_seq.sv | 116 +++++++++++
 tb/tb_tinv_bus_enable_seq.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/tinv_bus_enable_seq_pkg.sv
// tinv_bus_enable_seq_pkg: shared state encoding, counter sizing and parameter limits
package tinv_bus_pkg;
    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;
    localparam int NDRV_MIN = 2;
    localparam int NDRV_MAX = 16;
    localparam int DEAD_MIN = 1;
    localparam int DEAD_MAX = 15;
    function automatic int cnt_w(input int n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction
    function automatic bit dead_legal(input int d);
        return (d >= DEAD_MIN) && (d <= DEAD_MAX);
    endfunction
endpackage

// File: rtl/tinv_bus_enable_seq_if.sv
// tinv_bus_enable_seq_if: request/enable bundle between requesters and the tinv enable sequencer
interface tinv_bus_enable_seq_if #(parameter int NDRV = 4) ();
    logic [NDRV-1:0]         req;
    logic [NDRV-1:0]         en;
    logic [NDRV-1:0]         en_bar;
    logic [$clog2(NDRV)-1:0] owner;
    logic                    busy;
    logic                    preempt;
    modport master (output req, input en, en_bar, owner, busy, preempt);
    modport slave  (input req, output en, en_bar, owner, busy, preempt);
endinterface

// File: rtl/tinv_bus_enable_seq_rr_pick.sv
// tinv_rr_pick: combinational round-robin picker; first set request at or after start, wrapping
module tinv_rr_pick #(
    parameter int NDRV = 4
) (
    input  logic [NDRV-1:0]         req,
    input  logic [$clog2(NDRV)-1:0] start,
    output logic                    valid,
    output logic [$clog2(NDRV)-1:0] win
);
    localparam int IW = $clog2(NDRV);
    always_comb begin
        valid = |req;
        win = '0;
        for (int i = NDRV - 1; i >= 0; i--) begin
            int k;
            k = (int'(start) + i) % NDRV;
            if (req[k]) win = IW'(k);
        end
    end
endmodule

// File: rtl/tinv_bus_enable_seq.sv
// tinv_bus_enable_seq: round-robin tinv enable sequencer with break-before-make dead time.
// Optional TINV_BUS_PARK_EN keeps the last owner driving the net while idle.
module tinv_bus_enable_seq
    import tinv_bus_pkg::*;
#(
    parameter int NDRV    = 4,
    parameter int DEAD    = 1,
    parameter int MAX_TEN = 0
) (
    input logic                 clk,
    input logic                 rst,
    tinv_bus_enable_seq_if.slave bus
);
    localparam int       IW      = $clog2(NDRV);
    localparam int       TW      = cnt_w(MAX_TEN);
    localparam logic [3:0] DEAD_LD = 4'(DEAD - 1);
    if (!dead_legal(DEAD)) begin : g_bad_dead
        $error("DEAD must be in 1..15");
    end
    if (NDRV < NDRV_MIN || NDRV > NDRV_MAX) begin : g_bad_ndrv
        $error("NDRV must be in 2..16");
    end
    state_t          state;
    logic [NDRV-1:0] en, own_bit, others;
    logic [IW-1:0]   owner, start, win;
    logic [3:0]      dead;
    logic [TW-1:0]   ten;
    logic            valid, busy, preempt, ten_hit;
    assign own_bit     = NDRV'(1) << owner;
    assign others      = bus.req & ~own_bit;
    // Starting just past the owner makes the current (or preempted) owner rank lowest
    assign start       = (owner == IW'(NDRV - 1)) ? '0 : owner + 1'b1;
    assign ten_hit     = (MAX_TEN > 0) && (ten == TW'(MAX_TEN - 1)) && (|others);
    assign bus.en      = en;
    assign bus.en_bar  = ~en;
    assign bus.owner   = owner;
    assign bus.busy    = busy;
    assign bus.preempt = preempt;
    tinv_rr_pick #(.NDRV(NDRV)) u_pick (.req(bus.req), .start(start), .valid(valid), .win(win));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            en      <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
            dead    <= '0;
            ten     <= '0;
        end else begin
            preempt <= 1'b0;
            case (state)
                IDLE: begin
`ifdef TINV_BUS_PARK_EN
                    if (|en) begin
                        if (bus.req[owner]) begin
                            state <= DRIVE;
                            busy  <= 1'b1;
                            ten   <= '0;
                        end else if (|bus.req) begin
                            state <= TURN;
                            en    <= '0;
                            dead  <= DEAD_LD;
                        end
                    end else
`endif
                    if (valid) begin
                        state <= DRIVE;
                        en    <= NDRV'(1) << win;
                        owner <= win;
                        busy  <= 1'b1;
                        ten   <= '0;
                    end
                end
                DRIVE: begin
                    if (!bus.req[owner]) begin
`ifdef TINV_BUS_PARK_EN
                        if (others == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
`else
                        begin
`endif
                            state <= TURN;
                            en    <= '0;
                            busy  <= 1'b0;
                            dead  <= DEAD_LD;
                        end
                    end else if (ten_hit) begin
                        state   <= TURN;
                        en      <= '0;
                        busy    <= 1'b0;
                        preempt <= 1'b1;
                        dead    <= DEAD_LD;
                    end else if (ten != '1) begin
                        ten <= ten + 1'b1;
                    end
                end
                TURN: begin
                    if (dead != 4'd0) begin
                        dead <= dead - 4'd1;
                    end else if (valid) begin
                        state <= DRIVE;
                        en    <= NDRV'(1) << win;
                        owner <= win;
                        busy  <= 1'b1;
                        ten   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tinv_bus_enable_seq.sv
// tb_tinv_bus_enable_seq: scenario tasks with a per-cycle expected-output queue (NDRV=4, DEAD=2, MAX_TEN=4)
module tb_tinv_bus_enable_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   chk = 0;
    int   err = 0;
    logic [7:0] sb [$];
    tinv_bus_enable_seq_if #(.NDRV(4)) bus ();
    tinv_bus_enable_seq #(.NDRV(4), .DEAD(2), .MAX_TEN(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (!rst) begin
            chk++;
            if (bus.en_bar !== ~bus.en || !$onehot0(bus.en)) begin
                err++;
                $display("FAIL en_pair: got en=%b en_bar=%b, expected one-hot-or-zero en and en_bar=~en", bus.en, bus.en_bar);
            end
        end
    end
    // Expected entries are {en[3:0], owner[1:0], busy, preempt} after each edge
    task automatic test_reset();
        logic [11:0] g;
        bus.req = 4'b1111;
        repeat (2) @(posedge clk);
        #1;
        g = {bus.en, bus.en_bar, bus.owner, bus.busy, bus.preempt};
        chk++;
        if (g !== 12'b0000_1111_00_0_0) begin
            err++;
            $display("FAIL reset: got %b, expected %b", g, 12'b0000_1111_00_0_0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b0010;
        #1;
        g = {bus.en, bus.en_bar, bus.owner, bus.busy, bus.preempt};
        chk++;
        if (g !== 12'b0000_1111_00_0_0) begin
            err++;
            $display("FAIL reset_hold: got %b, expected %b", g, 12'b0000_1111_00_0_0);
        end
        bus.req = 4'b0000;
    endtask
    task automatic test_single();
        logic [3:0] rq [7] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        logic [7:0] ex [7] = '{8'b0010_01_10, 8'b0010_01_10, 8'b0010_01_10, 8'b0010_01_10,
                               8'b0000_01_00, 8'b0000_01_00, 8'b0000_01_00};
        logic [7:0] g, e;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            g = {bus.en, bus.owner, bus.busy, bus.preempt};
            e = sb.pop_front();
            chk++;
            if (g !== e) begin
                err++;
                $display("FAIL single row %0d: got en=%b owner=%0d busy=%b preempt=%b, expected en=%b owner=%0d busy=%b preempt=%b",
                         i, g[7:4], g[3:2], g[1], g[0], e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask
    task automatic test_handoff();
        logic [3:0] rq [9] = '{4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        logic [7:0] ex [9] = '{8'b0010_01_10, 8'b0010_01_10, 8'b0000_01_00, 8'b0000_01_00, 8'b0100_10_10,
                               8'b0100_10_10, 8'b0000_10_00, 8'b0000_10_00, 8'b0000_10_00};
        logic [7:0] g, e;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            g = {bus.en, bus.owner, bus.busy, bus.preempt};
            e = sb.pop_front();
            chk++;
            if (g !== e) begin
                err++;
                $display("FAIL handoff row %0d: got en=%b owner=%0d busy=%b preempt=%b, expected en=%b owner=%0d busy=%b preempt=%b",
                         i, g[7:4], g[3:2], g[1], g[0], e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask
    task automatic test_rr_wrap();
        logic [3:0] rq [11] = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b1000, 4'b1000, 4'b1000,
                                4'b0000, 4'b0000, 4'b0000};
        logic [7:0] ex [11] = '{8'b1000_11_10, 8'b0000_11_00, 8'b0000_11_00, 8'b0000_11_00, 8'b0001_00_10,
                                8'b0000_00_00, 8'b0000_00_00, 8'b1000_11_10, 8'b0000_11_00, 8'b0000_11_00,
                                8'b0000_11_00};
        logic [7:0] g, e;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            g = {bus.en, bus.owner, bus.busy, bus.preempt};
            e = sb.pop_front();
            chk++;
            if (g !== e) begin
                err++;
                $display("FAIL rr_wrap row %0d: got en=%b owner=%0d busy=%b preempt=%b, expected en=%b owner=%0d busy=%b preempt=%b",
                         i, g[7:4], g[3:2], g[1], g[0], e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask
    task automatic test_preempt();
        logic [3:0] rq [16] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011,
                                4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        logic [7:0] ex [16] = '{8'b0001_00_10, 8'b0001_00_10, 8'b0001_00_10, 8'b0001_00_10, 8'b0000_00_01,
                                8'b0000_00_00, 8'b0010_01_10, 8'b0010_01_10, 8'b0010_01_10, 8'b0010_01_10,
                                8'b0000_01_01, 8'b0000_01_00, 8'b0010_01_10, 8'b0000_01_00, 8'b0000_01_00,
                                8'b0000_01_00};
        logic [7:0] g, e;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            bus.req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            g = {bus.en, bus.owner, bus.busy, bus.preempt};
            e = sb.pop_front();
            chk++;
            if (g !== e) begin
                err++;
                $display("FAIL preempt row %0d: got en=%b owner=%0d busy=%b preempt=%b, expected en=%b owner=%0d busy=%b preempt=%b",
                         i, g[7:4], g[3:2], g[1], g[0], e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask
    task automatic test_release_at_limit();
        logic [3:0] rq [10] = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                                4'b0000, 4'b0000};
        logic [7:0] ex [10] = '{8'b0001_00_10, 8'b0001_00_10, 8'b0001_00_10, 8'b0001_00_10, 8'b0000_00_00,
                                8'b0000_00_00, 8'b0010_01_10, 8'b0000_01_00, 8'b0000_01_00, 8'b0000_01_00};
        logic [7:0] g, e;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            g = {bus.en, bus.owner, bus.busy, bus.preempt};
            e = sb.pop_front();
            chk++;
            if (g !== e) begin
                err++;
                $display("FAIL release_at_limit row %0d: got en=%b owner=%0d busy=%b preempt=%b, expected en=%b owner=%0d busy=%b preempt=%b",
                         i, g[7:4], g[3:2], g[1], g[0], e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask
`ifdef TINV_BUS_PARK_EN
    task automatic test_park();
        logic [3:0] rq [8] = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic [7:0] ex [8] = '{8'b0010_01_10, 8'b0010_01_00, 8'b0010_01_10, 8'b0010_01_00, 8'b0000_01_00,
                               8'b0000_01_00, 8'b0001_00_10, 8'b0001_00_00};
        logic [7:0] g, e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.req = rq[i];
            sb.push_back(ex[i]);
            @(posedge clk);
            #1;
            g = {bus.en, bus.owner, bus.busy, bus.preempt};
            e = sb.pop_front();
            chk++;
            if (g !== e) begin
                err++;
                $display("FAIL park row %0d: got en=%b owner=%0d busy=%b preempt=%b, expected en=%b owner=%0d busy=%b preempt=%b",
                         i, g[7:4], g[3:2], g[1], g[0], e[7:4], e[3:2], e[1], e[0]);
            end
        end
    endtask
`endif
    task automatic test_reset_mid_drive();
        logic [11:0] g;
        @(negedge clk);
        bus.req = 4'b0100;
        @(posedge clk);
        #1;
        chk++;
        if ({bus.en, bus.owner} !== 6'b0100_10) begin
            err++;
            $display("FAIL mid_grant: got en=%b owner=%0d, expected en=0100 owner=2", bus.en, bus.owner);
        end
        #2;
        rst = 1'b1;
        #1;
        g = {bus.en, bus.en_bar, bus.owner, bus.busy, bus.preempt};
        chk++;
        if (g !== 12'b0000_1111_00_0_0) begin
            err++;
            $display("FAIL reset_mid_drive: got %b, expected %b", g, 12'b0000_1111_00_0_0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b0000;
        @(posedge clk);
        #1;
        chk++;
        if ({bus.en, bus.owner, bus.busy} !== 7'b0000_00_0) begin
            err++;
            $display("FAIL post_reset_idle: got en=%b owner=%0d busy=%b, expected en=0000 owner=0 busy=0", bus.en, bus.owner, bus.busy);
        end
    endtask
    initial begin
        bus.req = 4'b0000;
        test_reset();
        test_single();
        test_handoff();
        test_rr_wrap();
        test_preempt();
        test_release_at_limit();
`ifdef TINV_BUS_PARK_EN
        test_park();
`endif
        test_reset_mid_drive();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end
endmodule
